store_buffer_drain: RTL

//  Downstream consumer of the D-cache store buffer: pops the oldest buffered store and commits it to the
//  D-cache data-array write port. Loads have priority; a drain starts on full buffer, flush, or idle window.

---
 rtl/store_buffer_drain_pkg.sv | 29 ++
 rtl/store_buffer_drain_sat_counter.sv | 38 +++
 rtl/store_buffer_drain.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/store_buffer_drain_pkg.sv
// Shared types for the store-buffer drain engine: store entry payload, FSM
// state encoding and idle-counter width.
package store_buffer_drain_pkg;

    localparam int unsigned ST_DRAIN_IDLE_CNT_WIDTH = 4;
    localparam int unsigned SB_ADDR_W               = 32;
    localparam int unsigned SB_DATA_W               = 32;
    localparam int unsigned SB_WAY_W                = 2;
    localparam int unsigned SB_SIZE_W               = 2;
    localparam int unsigned SB_TID_W                = 2;
    localparam int unsigned PERF_CNT_W              = 32;

    // One buffered store as handed over by the store buffer
    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_WAY_W-1:0]  way;
        logic [SB_DATA_W-1:0] data;
        logic [SB_SIZE_W-1:0] size;
        logic [SB_TID_W-1:0]  thread_id;
    } store_buffer_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        REQ  = 2'd2,
        WAIT = 2'd3
    } st_drain_state_t;

endpackage

// File: rtl/store_buffer_drain_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module store_buffer_drain_sat_counter
    import store_buffer_drain_pkg::*;
#(
    parameter int unsigned WIDTH = ST_DRAIN_IDLE_CNT_WIDTH
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, else increment until all-ones
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/store_buffer_drain.sv
// Store-buffer drain engine: pops the oldest buffered store and commits it to
// the D-cache data-array write port. Drains on full buffer, flush, or after an
// idle window free of loads.
// Optional build macro ST_DRAIN_PERF_CNT_EN adds committed-store and stall counters.
module store_buffer_drain
    import store_buffer_drain_pkg::*;
#(
    parameter int unsigned IDLE_DRAIN_CYCLES = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  sb_empty_i,
    input  logic                  sb_full_i,
    input  store_buffer_t         sb_oldest_info_i,
    output logic                  sb_get_oldest_o,
    output logic                  sb_search_block_o,
    input  logic                  load_active_i,
    input  logic                  flush_req_i,
    output logic                  flush_done_o,
    output logic                  wr_req_valid_o,
    output store_buffer_t         wr_req_info_o,
    input  logic                  wr_req_ready_i,
    input  logic                  wr_done_i,
    output logic [PERF_CNT_W-1:0] perf_drained_o,
    output logic [PERF_CNT_W-1:0] perf_stall_o
);

    st_drain_state_t                      state_q;
    store_buffer_t                        entry_q;
    logic                                 get_q;
    logic                                 block_q;
    logic                                 wr_valid_q;
    logic                                 flush_done_q;
    logic                                 flush_pending_q;
    logic [ST_DRAIN_IDLE_CNT_WIDTH-1:0]   idle_cnt;
    logic                                 idle_window_c;
    logic                                 drain_start_c;
    logic                                 drain_more_c;

    // Load-free cycle counter; restarts on any load and on every pop
    store_buffer_drain_sat_counter #(
        .WIDTH (ST_DRAIN_IDLE_CNT_WIDTH)
    ) u_idle_cnt (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .inc_i   (!load_active_i),
        .clr_i   (load_active_i || (state_q == POP)),
        .count_o (idle_cnt)
    );

    // Drain triggers; a full buffer overrides load priority to avoid deadlock
    always_comb begin
        idle_window_c = (idle_cnt >= ST_DRAIN_IDLE_CNT_WIDTH'(IDLE_DRAIN_CYCLES)) && !load_active_i;
        drain_start_c = !sb_empty_i && (sb_full_i || flush_pending_q || idle_window_c);
        drain_more_c  = !sb_empty_i && (sb_full_i || flush_pending_q);
    end

    // Drain FSM with registered outputs, entry capture and flush tracking
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            entry_q         <= '0;
            get_q           <= 1'b0;
            block_q         <= 1'b0;
            wr_valid_q      <= 1'b0;
            flush_done_q    <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            get_q        <= 1'b0;
            block_q      <= 1'b0;
            flush_done_q <= 1'b0;
            if (flush_req_i) begin
                flush_pending_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (drain_start_c) begin
                        state_q <= POP;
                        get_q   <= 1'b1;
                        block_q <= 1'b1;
                    end else if ((flush_pending_q || flush_req_i) && sb_empty_i) begin
                        flush_done_q    <= 1'b1;
                        flush_pending_q <= 1'b0;
                    end
                end
                POP: begin
                    entry_q    <= sb_oldest_info_i;
                    state_q    <= REQ;
                    wr_valid_q <= 1'b1;
                end
                REQ: begin
                    if (wr_req_ready_i) begin
                        state_q    <= WAIT;
                        wr_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (wr_done_i) begin
                        if (drain_more_c) begin
                            state_q <= POP;
                            get_q   <= 1'b1;
                            block_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sb_get_oldest_o   = get_q;
    assign sb_search_block_o = block_q;
    assign wr_req_valid_o    = wr_valid_q;
    assign wr_req_info_o     = entry_q;
    assign flush_done_o      = flush_done_q;

`ifdef ST_DRAIN_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] drained_q;
    logic [PERF_CNT_W-1:0] stall_q;

    // Committed-store and write-port stall counters, free-running wrap
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            drained_q <= '0;
            stall_q   <= '0;
        end else begin
            if ((state_q == WAIT) && wr_done_i) begin
                drained_q <= drained_q + PERF_CNT_W'(1);
            end
            if ((state_q == REQ) && !wr_req_ready_i) begin
                stall_q <= stall_q + PERF_CNT_W'(1);
            end
        end
    end

    assign perf_drained_o = drained_q;
    assign perf_stall_o   = stall_q;
`else
    assign perf_drained_o = '0;
    assign perf_stall_o   = '0;
`endif

endmodule
